wb_cfg_loader: RTL and testbench
================================

Name: wb_cfg_loader

Overview:
- Wishbone slave that accepts FPGA configuration words from the management core and buffers them in a FIFO.
- Serialises the words LSB-first into one of NUM_CHAINS configuration shift chains of the FPGA fabric.
- Sits between the Wishbone port of the top-level wrapper and the fabric config chains.
- Generalises the fixed single-path config hookup: parametrised chain count, FIFO depth and chain length, with status and an interrupt.

Parameters:
- NUM_CHAINS, 4, number of independent config chains (1..16).
- FIFO_DEPTH, 8, config-word FIFO entries; power of two, at least 2.
- LEN_W, 20, width of the per-load bit-length register.
- BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rstn_i  in  1  reset; synchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- cfg_data_o  out  NUM_CHAINS  serial config data, one bit per chain.
- cfg_shift_o  out  NUM_CHAINS  shift enable per chain; one-hot or zero.
- cfg_done_o  out  1  level, high from load completion until the next start.
- irq_o  out  1  level interrupt = done & irq_en.

Behaviour:
Reset:
- On a clock edge with wb_rstn_i=0: all outputs 0, FSM to IDLE, FIFO emptied, all registers 0.
- Reset mid-shift abandons the load at once; no partial done and no irq.

Wishbone:
- Hit = stb & cyc & address match & !ack.
- ack asserts exactly one cycle after a hit, for one cycle.
- Back-to-back accesses therefore take at least 2 cycles each.
- A non-matching address gets no ack.
- Unmapped offsets inside the window: ack, reads return 0, writes have no effect.

Registers (offset = adr[7:2]):
- 0x00 CTRL, W:
  - bit0 start (self-clearing).
  - bit1 abort (self-clearing).
  - bit2 irq_en (sticky).
  - bits[7:4] chain_sel.
  - Read returns irq_en and chain_sel.
- 0x04 LEN, RW: bits to shift, LEN_W bits; upper bits read 0.
- 0x08 DATA, W: push to FIFO. Read returns 0.
- 0x0C STATUS, R:
  - bit0 busy, bit1 done, bit2 full, bit3 empty, bit4 overflow (sticky).
  - bits[15:8] FIFO level.
  - Reading STATUS clears overflow.

DATA writes:
- A DATA write when the FIFO is full is still acked; the word is dropped and overflow is set.
- No stall is permitted: the management bus must never hang.

FSM (IDLE, FETCH, SHIFT, DONE):
- IDLE:
  - start with LEN>0 and chain_sel<NUM_CHAINS: latch chain and remaining=LEN, clear done, go to FETCH.
  - start with LEN=0: go to DONE next cycle; nothing shifted.
  - start with chain_sel>=NUM_CHAINS: ignored, stay IDLE.
- FETCH:
  - Wait while the FIFO is empty (busy stays 1).
  - When non-empty: pop into a 32-bit shift register, go to SHIFT. Costs one cycle.
- SHIFT:
  - Each cycle: cfg_data_o[ch]=sreg[0], cfg_shift_o[ch]=1, sreg>>=1, remaining--.
  - After 32 bits, or when remaining reaches 0, go to FETCH or DONE respectively.
  - The unused upper bits of the last word are discarded.
- DONE: set done (cfg_done_o=1), go to IDLE; done holds until the next start.

Control edge cases:
- start while busy: ignored.
- CTRL write with both start and abort set: abort wins.
- abort, any state: IDLE next cycle, shift outputs 0 that cycle, FIFO flushed, done not set, overflow kept.
- A simultaneous FIFO push and pop is legal at any level, including full; the level is unchanged.
- The FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty detection.

Outputs:
- cfg_data_o is 0 on every chain whose shift enable is low.
- irq_o is combinational from registered state.

Decomposition:
- Package wb_cfg_loader_pkg:
  - Register offset constants.
  - CTRL/STATUS bit-position constants.
  - FSM state enum.
- Sub-module cfg_fifo:
  - Synchronous FIFO, 32 bits wide × FIFO_DEPTH.
  - Ports: push, pop, dout, full, empty, level, flush.
  - Same clock and synchronous active-low reset.

Test Plan:
- Reset, then read STATUS: ack after 1 cycle; data 0x0000_0008 (empty=1, level 0); all cfg outputs 0.
- LEN=40, chain_sel=2, DATA 0xA5A5_A5A5 and 0x0000_00FF, start:
  - cfg_shift_o=4'b0100 for exactly 40 cycles.
  - Serial stream is 0xA5A5_A5A5 LSB-first, then 8 ones.
  - Then cfg_done_o=1; irq_o=1 if irq_en was set.
- Write 9 DATA words with FIFO_DEPTH=8, no start:
  - All 9 writes acked.
  - STATUS reads 0x0814 (level 8, full, overflow).
  - A second STATUS read has overflow cleared.
- start with an empty FIFO, LEN=8:
  - busy=1, no shifting.
  - DATA 0x0000_0081 written 20 cycles later: 8 shift cycles with bits 1,0,0,0,0,0,0,1, then done.
- abort written 10 bits into a 64-bit load: outputs 0 next cycle, FSM IDLE, FIFO empty, done=0.
- Edge starts:
  - LEN=0 start: done the next cycle with zero shift pulses.
  - chain_sel=5 with NUM_CHAINS=4: start ignored, busy stays 0.

Source files
------------

// File: rtl/wb_cfg_loader_pkg.sv
// Shared constants and types for the Wishbone configuration loader.
package wb_cfg_loader_pkg;

  // Register word offsets (byte address bits [7:2])
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_LEN    = 6'h01;
  localparam logic [5:0] OFF_DATA   = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_SEL_LO = 4;
  localparam int CTRL_SEL_HI = 7;

  // STATUS bit positions
  localparam int STS_BUSY   = 0;
  localparam int STS_DONE   = 1;
  localparam int STS_FULL   = 2;
  localparam int STS_EMPTY  = 3;
  localparam int STS_OVF    = 4;
  localparam int STS_LVL_LO = 8;

  // Width of one configuration word
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_cfg_loader_fifo.sv
// Synchronous first-word-fall-through FIFO holding configuration words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cfg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a push into a full FIFO is accepted only alongside a pop
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone slave that buffers configuration words and shifts them LSB-first
// into one of NUM_CHAINS fabric configuration chains.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; shift outputs quiet
//   S_FETCH | waiting for a word in the FIFO, then pops it into sreg
//   S_SHIFT | one bit per cycle onto the selected chain
//   S_DONE  | load finished; raises done and returns to idle
module wb_cfg_loader
  import wb_cfg_loader_pkg::*;
#(
  parameter int          NUM_CHAINS = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LEN_W      = 20,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NUM_CHAINS-1:0] cfg_data_o,
  output logic [NUM_CHAINS-1:0] cfg_shift_o,
  output logic                  cfg_done_o,
  output logic                  irq_o
);

  localparam int         LVL_W        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] NUM_CHAINS_L = 5'(NUM_CHAINS);
  localparam logic [4:0] BIT_LAST     = 5'(WORD_W - 1);

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_en_q, irq_en_d;
  logic [3:0]            chain_sel_q, chain_sel_d;
  logic [3:0]            chain_q, chain_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [WORD_W-1:0]     sreg_q, sreg_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_CHAINS-1:0] shift_q, shift_d;
  logic [NUM_CHAINS-1:0] data_q, data_d;
  logic [NUM_CHAINS-1:0] chain_oh;

  logic                  adr_match, wb_hit, wr_hit, rd_hit;
  logic [5:0]            reg_off;
  logic                  ctrl_wr, len_wr, data_wr;
  logic                  start_req, abort_req;
  logic [3:0]            new_sel;
  logic [31:0]           status_w;

  logic                  fifo_pop, fifo_flush;
  logic [WORD_W-1:0]     fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level;
  logic                  unused_ok;

  // Byte lanes and the byte offset within a word play no role
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

  assign adr_match = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wb_hit    = wbs_stb_i & wbs_cyc_i & adr_match & ~ack_q;
  assign wr_hit    = wb_hit & wbs_we_i;
  assign rd_hit    = wb_hit & ~wbs_we_i;
  assign reg_off   = wbs_adr_i[7:2];
  assign ctrl_wr   = wr_hit & (reg_off == OFF_CTRL);
  assign len_wr    = wr_hit & (reg_off == OFF_LEN);
  assign data_wr   = wr_hit & (reg_off == OFF_DATA);
  assign abort_req = ctrl_wr & wbs_dat_i[CTRL_ABORT];
  assign start_req = ctrl_wr & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT];
  assign new_sel   = wbs_dat_i[CTRL_SEL_HI:CTRL_SEL_LO];

  cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .push  (data_wr),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wbs_dat_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // STATUS read word assembled from live state
  always_comb begin
    status_w                    = '0;
    status_w[STS_BUSY]          = (state_q != S_IDLE);
    status_w[STS_DONE]          = done_q;
    status_w[STS_FULL]          = fifo_full;
    status_w[STS_EMPTY]         = fifo_empty;
    status_w[STS_OVF]           = ovf_q;
    status_w[STS_LVL_LO +: 8]   = 8'(fifo_level);
  end

  // Next-state logic: bus registers, loader FSM, registered chain outputs
  always_comb begin
    state_d     = state_q;
    ack_d       = wb_hit;
    rdata_d     = '0;
    irq_en_d    = irq_en_q;
    chain_sel_d = chain_sel_q;
    chain_d     = chain_q;
    len_d       = len_q;
    rem_d       = rem_q;
    sreg_d      = sreg_q;
    bitcnt_d    = bitcnt_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    if (ctrl_wr) begin
      irq_en_d    = wbs_dat_i[CTRL_IRQ_EN];
      chain_sel_d = new_sel;
    end
    if (len_wr) len_d = wbs_dat_i[LEN_W-1:0];

    if (rd_hit) begin
      case (reg_off)
        OFF_CTRL:   rdata_d = {24'b0, chain_sel_q, 1'b0, irq_en_q, 2'b0};
        OFF_LEN:    rdata_d = 32'(len_q);
        OFF_STATUS: rdata_d = status_w;
        default:    rdata_d = '0;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req && ({1'b0, new_sel} < NUM_CHAINS_L)) begin
          done_d  = 1'b0;
          chain_d = new_sel;
          rem_d   = len_q;
          state_d = (len_q == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sreg_d   = fifo_dout;
          bitcnt_d = BIT_LAST;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_q >> 1;
        rem_d  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else if (bitcnt_q == '0) begin
          state_d = S_FETCH;
        end else begin
          bitcnt_d = bitcnt_q - 5'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the FSM decided this cycle
    if (abort_req) begin
      state_d    = S_IDLE;
      done_d     = done_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end

    if (rd_hit && (reg_off == OFF_STATUS)) ovf_d = 1'b0;
    if (data_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;

    // Chain outputs are registered: drive the bit that sreg_d will present
    chain_oh = NUM_CHAINS'(1) << chain_d;
    if (state_d == S_SHIFT) begin
      shift_d = chain_oh;
      data_d  = chain_oh & {NUM_CHAINS{sreg_d[0]}};
    end else begin
      shift_d = '0;
      data_d  = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      irq_en_q    <= 1'b0;
      chain_sel_q <= '0;
      chain_q     <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      irq_en_q    <= irq_en_d;
      chain_sel_q <= chain_sel_d;
      chain_q     <= chain_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      sreg_q      <= sreg_d;
      bitcnt_q    <= bitcnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdata_q;
  assign cfg_shift_o = shift_q;
  assign cfg_data_o  = data_q;
  assign cfg_done_o  = done_q;
  assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Directed bench for wb_cfg_loader with hand-computed expectations.
module tb_wb_cfg_loader;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_LEN    = 32'h3000_0004;
  localparam logic [31:0] A_DATA   = 32'h3000_0008;
  localparam logic [31:0] A_STATUS = 32'h3000_000C;
  localparam logic [31:0] A_UNMAP  = 32'h3000_0010;
  localparam logic [31:0] A_MISS   = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [3:0]  cfg_data, cfg_shift;
  logic        done, irq;

  always #5 clk = ~clk;

  wb_cfg_loader dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .cfg_data_o  (cfg_data),
    .cfg_shift_o (cfg_shift),
    .cfg_done_o  (done),
    .irq_o       (irq)
  );

  int   n_pass   = 0;
  int   n_checks = 0;
  int   pulses   = 0;
  int   data_leak = 0;
  int   bad_acks = 0;
  int   wr_acks  = 0;
  logic [3:0] shift_or = '0;
  logic bits_q[$];

  // Chain monitor sampled on the falling edge
  always @(negedge clk) begin
    if (cfg_shift != 4'b0) begin
      pulses++;
      shift_or |= cfg_shift;
      bits_q.push_back(|(cfg_data & cfg_shift));
    end
    if ((cfg_data & ~cfg_shift) != 4'b0) data_leak++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clr_mon();
    pulses   = 0;
    shift_or = '0;
    bits_q.delete();
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = n;
        rd  = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    int lat;
    xfer(1'b1, a, d, dummy, lat);
    if (lat == 1) wr_acks++;
    else bad_acks++;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    int lat;
    xfer(1'b0, a, 32'h0, d, lat);
    if (lat != 1) bad_acks++;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (done) break;
    end
  endtask

  task automatic wait_pulses(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (pulses >= target) break;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] w;
    int          lat;
    int          base;

    rstn = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'hF; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    chk("rst_shift", 32'(cfg_shift), 32'h0);
    chk("rst_data", 32'(cfg_data), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    xfer(1'b0, A_STATUS, 32'h0, v, lat);
    chk("rst_status_lat", 32'(lat), 32'd1);
    chk("rst_status", v, 32'h0000_0008);

    // Overflow: nine pushes into an eight-deep FIFO
    base = wr_acks;
    for (int i = 1; i <= 9; i++) wr(A_DATA, 32'(i));
    chk("ovf_acks", 32'(wr_acks - base), 32'd9);
    rd(A_STATUS, v);
    chk("ovf_status1", v, 32'h0000_0814);
    rd(A_STATUS, v);
    chk("ovf_status2", v, 32'h0000_0804);

    // Register map corners
    wr(A_LEN, 32'hFFFF_FFFF);
    rd(A_LEN, v);
    chk("len_mask", v, 32'h000F_FFFF);
    rd(A_DATA, v);
    chk("data_rd", v, 32'h0);
    rd(A_UNMAP, v);
    chk("unmap_rd", v, 32'h0);
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_STATUS, v);
    chk("unmap_wr", v, 32'h0000_0804);
    xfer(1'b0, A_MISS, 32'h0, v, lat);
    chk("miss_noack", 32'(lat), 32'd0);

    // Abort while idle flushes the FIFO
    wr(A_CTRL, 32'h0000_0002);
    rd(A_STATUS, v);
    chk("flush_status", v, 32'h0000_0008);

    // Two-word load on chain 2 with interrupt enabled
    wr(A_LEN, 32'd40);
    wr(A_DATA, 32'hA5A5_A5A5);
    wr(A_DATA, 32'h0000_00FF);
    clr_mon();
    wr(A_CTRL, 32'h0000_0025);
    wait_done(200);
    chk("load_done", 32'(done), 32'h1);
    chk("load_pulses", 32'(pulses), 32'd40);
    chk("load_chain", 32'(shift_or), 32'h4);
    w = '0;
    for (int i = 0; i < 32; i++) if (i < bits_q.size()) w[i] = bits_q[i];
    chk("load_word0", w, 32'hA5A5_A5A5);
    w = '0;
    for (int i = 0; i < 8; i++) if (32 + i < bits_q.size()) w[i] = bits_q[32 + i];
    chk("load_word1", w, 32'h0000_00FF);
    chk("load_irq", 32'(irq), 32'h1);
    rd(A_STATUS, v);
    chk("load_status", v, 32'h0000_000A);
    rd(A_CTRL, v);
    chk("ctrl_rd", v, 32'h0000_0024);

    // Start with an empty FIFO; data arrives later
    wr(A_LEN, 32'd8);
    clr_mon();
    wr(A_CTRL, 32'h0000_0001);
    chk("starve_done_clr", 32'(done), 32'h0);
    repeat (20) @(posedge clk);
    #1;
    rd(A_STATUS, v);
    chk("starve_status", v, 32'h0000_0009);
    chk("starve_pulses0", 32'(pulses), 32'd0);
    wr(A_DATA, 32'h0000_0081);
    wait_done(100);
    chk("starve_done", 32'(done), 32'h1);
    chk("starve_pulses", 32'(pulses), 32'd8);
    w = '0;
    for (int i = 0; i < 8; i++) if (i < bits_q.size()) w[i] = bits_q[i];
    chk("starve_bits", w, 32'h0000_0081);
    chk("starve_chain", 32'(shift_or), 32'h1);
    chk("starve_irq_off", 32'(irq), 32'h0);

    // Abort part-way through a 64-bit load on chain 1
    wr(A_LEN, 32'd64);
    wr(A_DATA, 32'hFFFF_FFFF);
    wr(A_DATA, 32'h1234_5678);
    clr_mon();
    wr(A_CTRL, 32'h0000_0011);
    wait_pulses(10, 100);
    wr(A_CTRL, 32'h0000_0002);
    chk("abort_shift", 32'(cfg_shift), 32'h0);
    chk("abort_data", 32'(cfg_data), 32'h0);
    chk("abort_chain", 32'(shift_or), 32'h2);
    base = pulses;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_quiet", 32'(pulses - base), 32'd0);
    chk("abort_done", 32'(done), 32'h0);
    rd(A_STATUS, v);
    chk("abort_status", v, 32'h0000_0008);

    // LEN = 0 completes without shifting
    wr(A_LEN, 32'd0);
    clr_mon();
    wr(A_CTRL, 32'h0000_0001);
    wait_done(3);
    chk("len0_done", 32'(done), 32'h1);
    chk("len0_pulses", 32'(pulses), 32'd0);

    // Out-of-range chain select is ignored
    wr(A_LEN, 32'd8);
    clr_mon();
    wr(A_CTRL, 32'h0000_0051);
    repeat (3) @(posedge clk);
    #1;
    rd(A_STATUS, v);
    chk("badsel_status", v, 32'h0000_000A);
    chk("badsel_pulses", 32'(pulses), 32'd0);

    // Reset in the middle of a shift
    wr(A_LEN, 32'd32);
    wr(A_DATA, 32'hDEAD_BEEF);
    clr_mon();
    wr(A_CTRL, 32'h0000_0035);
    wait_pulses(5, 100);
    chk("rstmid_chain", 32'(shift_or), 32'h8);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_shift", 32'(cfg_shift), 32'h0);
    chk("rstmid_data", 32'(cfg_data), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    chk("rstmid_irq", 32'(irq), 32'h0);
    rstn = 1'b1;
    rd(A_STATUS, v);
    chk("rstmid_status", v, 32'h0000_0008);
    rd(A_CTRL, v);
    chk("rstmid_ctrl", v, 32'h0);

    chk("data_leak", 32'(data_leak), 32'd0);
    chk("bad_acks", 32'(bad_acks), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
